reorder_buffer: RTL and testbench

//  In-order retirement queue between issue/execute and the register file. Allocates a tag per issued

---
 rtl/rob_pkg.sv | 15 +
 rtl/rob_ptr_ctrl.sv | 46 ++++
 rtl/reorder_buffer.sv | 115 +++++++++++
 tb/tb_reorder_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared ROB types and defaults for the reorder buffer and its pointer controller.
// Optional feature macro: ROB_COMMIT_BYPASS_EN (see reorder_buffer.sv).
package rob_pkg;
  localparam int ROB_WIDTH = 3;
  localparam int XLEN      = 32;
  localparam int ROB_DEPTH = 1 << ROB_WIDTH;

  typedef struct packed {
    logic            busy;
    logic            ready;
    logic            has_rd;
    logic [4:0]      rd;
    logic [XLEN-1:0] value;
  } rob_entry_t;
endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy tracking for the reorder buffer. Pointers wrap naturally at
// 2^ROB_WIDTH; count carries one extra bit so full and empty are distinguishable.
module rob_ptr_ctrl
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH = rob_pkg::ROB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic                 issue,
  input  logic                 commit,
  output logic [ROB_WIDTH-1:0] head,
  output logic [ROB_WIDTH-1:0] tail,
  output logic [ROB_WIDTH:0]   count,
  output logic                 full,
  output logic                 empty
);
  // Count can only reach 2^ROB_WIDTH when full, so its MSB alone flags full.
  assign full  = count[ROB_WIDTH];
  assign empty = (count == '0);

  // Pointer/count update; freeze holds everything, flush rewinds to the origin.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (issue)  tail <= tail + 1'b1;
        if (commit) head <= head + 1'b1;
        case ({issue, commit})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates tags at issue, captures CDB results,
// retires the oldest completed entry to the register file one per cycle.
// Optional macro ROB_COMMIT_BYPASS_EN: a CDB result targeting the head entry
// retires on the same edge it is broadcast, with the value taken from the bus.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_WIDTH = rob_pkg::ROB_WIDTH,
  parameter int XLEN      = rob_pkg::XLEN
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 from_dec_valid,
  input  logic                 from_dec_has_rd,
  input  logic [4:0]           from_dec_rd,
  output logic                 to_dec_full,
  output logic [ROB_WIDTH-1:0] to_dec_tag,
  input  logic                 from_cdb_valid,
  input  logic [ROB_WIDTH-1:0] from_cdb_tag,
  input  logic [XLEN-1:0]      from_cdb_value,
  input  logic                 from_flush,
  output logic                 to_rf_valid,
  output logic [4:0]           to_rf_rd,
  output logic [XLEN-1:0]      to_rf_wdata,
  output logic [ROB_WIDTH-1:0] to_rf_tag
);
  localparam int DEPTH = 1 << ROB_WIDTH;

  rob_entry_t             rob [DEPTH];
  logic [ROB_WIDTH-1:0]   head, tail;
  logic [ROB_WIDTH:0]     count;
  logic                   full, empty;
  logic                   issue_fire, commit_fire;
  logic [XLEN-1:0]        commit_value;

  rob_ptr_ctrl #(.ROB_WIDTH(ROB_WIDTH)) u_ptr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (from_flush),
    .issue  (issue_fire),
    .commit (commit_fire),
    .head   (head),
    .tail   (tail),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign to_dec_full = full;
  assign to_dec_tag  = tail;

  // Full is taken from the pre-edge count, so a same-cycle commit never frees a slot for issue.
  assign issue_fire = rdy_in && !from_flush && from_dec_valid && !full;

`ifdef ROB_COMMIT_BYPASS_EN
  logic cdb_hits_head;
  assign cdb_hits_head = from_cdb_valid && (from_cdb_tag == head);
  // Head retires on its stored ready bit or directly off the bus; stored value wins if both.
  assign commit_fire  = rdy_in && !from_flush && !empty && rob[head].busy &&
                        (rob[head].ready || cdb_hits_head);
  assign commit_value = rob[head].ready ? rob[head].value : from_cdb_value;
`else
  // Head retires only once its result has been captured on an earlier edge.
  assign commit_fire  = rdy_in && !from_flush && !empty && rob[head].busy && rob[head].ready;
  assign commit_value = rob[head].value;
`endif

  // Entry array: flush clears everything; otherwise writeback, retire, allocate (last write wins).
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
    end else if (rdy_in) begin
      if (from_flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          rob[i].busy  <= 1'b0;
          rob[i].ready <= 1'b0;
        end
      end else begin
        if (from_cdb_valid && rob[from_cdb_tag].busy) begin
          rob[from_cdb_tag].value <= from_cdb_value;
          rob[from_cdb_tag].ready <= 1'b1;
        end
        if (commit_fire) begin
          rob[head].busy  <= 1'b0;
          rob[head].ready <= 1'b0;
        end
        if (issue_fire) begin
          rob[tail].busy   <= 1'b1;
          rob[tail].ready  <= 1'b0;
          rob[tail].has_rd <= from_dec_has_rd;
          rob[tail].rd     <= from_dec_rd;
        end
      end
    end
  end

  // Commit port registers: strobe is a one-cycle pulse, x0/no-rd entries retire silently.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      to_rf_valid <= 1'b0;
      to_rf_rd    <= '0;
      to_rf_wdata <= '0;
      to_rf_tag   <= '0;
    end else if (!rdy_in || from_flush || !commit_fire) begin
      to_rf_valid <= 1'b0;
    end else begin
      to_rf_valid <= rob[head].has_rd && (rob[head].rd != 5'd0);
      to_rf_rd    <= rob[head].rd;
      to_rf_wdata <= commit_value;
      to_rf_tag   <= head;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based model of in-flight instructions
// predicts every output each cycle; literal checks pin key scenarios.
module tb_reorder_buffer;
  logic        clk = 0, rst_n = 0, rdy = 1;
  logic        dec_valid = 0, dec_has_rd = 0;
  logic [4:0]  dec_rd = 0;
  logic        full;
  logic [2:0]  dec_tag;
  logic        cdb_valid = 0;
  logic [2:0]  cdb_tag = 0;
  logic [31:0] cdb_value = 0;
  logic        flush = 0;
  logic        rf_valid;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [2:0]  rf_tag;

  int n_cmp = 0, n_fail = 0;
  bit chk_en = 0;

  reorder_buffer dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
    .from_dec_valid(dec_valid), .from_dec_has_rd(dec_has_rd), .from_dec_rd(dec_rd),
    .to_dec_full(full), .to_dec_tag(dec_tag),
    .from_cdb_valid(cdb_valid), .from_cdb_tag(cdb_tag), .from_cdb_value(cdb_value),
    .from_flush(flush),
    .to_rf_valid(rf_valid), .to_rf_rd(rf_rd), .to_rf_wdata(rf_wdata), .to_rf_tag(rf_tag)
  );

  always #5 clk = ~clk;

  // Model: program-order list of in-flight instructions.
  typedef struct {
    logic [2:0]  tag;
    bit          has_rd;
    logic [4:0]  rd;
    bit          ready;
    logic [31:0] value;
  } inst_t;

  inst_t       q[$];
  logic [2:0]  m_next = 0;
  bit          m_valid = 0;
  logic [4:0]  m_rd = 0;
  logic [31:0] m_wdata = 0;
  logic [2:0]  m_tag = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit          pre_full, do_c;
    logic [31:0] cv;
    if (!rst_n) begin
      q.delete(); m_next = 0; m_valid = 0; m_rd = 0; m_wdata = 0; m_tag = 0;
    end else if (!rdy) begin
      m_valid = 0;
    end else if (flush) begin
      q.delete(); m_next = 0; m_valid = 0;
    end else begin
      pre_full = (q.size() == 8);
      do_c = 0; cv = 0;
      if (q.size() > 0) begin
        if (q[0].ready) begin do_c = 1; cv = q[0].value; end
`ifdef ROB_COMMIT_BYPASS_EN
        else if (cdb_valid && cdb_tag == q[0].tag) begin do_c = 1; cv = cdb_value; end
`endif
      end
      if (cdb_valid)
        foreach (q[i]) if (q[i].tag == cdb_tag) begin q[i].ready = 1; q[i].value = cdb_value; end
      if (do_c) begin
        m_valid = q[0].has_rd && (q[0].rd != 0);
        m_rd = q[0].rd; m_wdata = cv; m_tag = q[0].tag;
        void'(q.pop_front());
      end else m_valid = 0;
      if (dec_valid && !pre_full) begin
        q.push_back('{tag: m_next, has_rd: dec_has_rd, rd: dec_rd, ready: 0, value: 0});
        m_next = m_next + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) if (chk_en) begin
    chk("full",     64'(full),     64'(q.size() == 8));
    chk("dec_tag",  64'(dec_tag),  64'(m_next));
    chk("rf_valid", 64'(rf_valid), 64'(m_valid));
    chk("rf_rd",    64'(rf_rd),    64'(m_rd));
    chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
    chk("rf_tag",   64'(rf_tag),   64'(m_tag));
  end

  task automatic step(input bit v, input bit hr, input logic [4:0] rd,
                      input bit cv, input logic [2:0] ct, input logic [31:0] cval, input bit fl);
    dec_valid = v; dec_has_rd = hr; dec_rd = rd;
    cdb_valid = cv; cdb_tag = ct; cdb_value = cval; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic iss(input logic [4:0] rd); step(1, 1, rd, 0, 0, 0, 0); endtask
  task automatic cdb(input logic [2:0] t, input logic [31:0] v); step(0, 0, 0, 1, t, v, 0); endtask
  task automatic fl(); step(0, 0, 0, 0, 0, 0, 1); endtask

  initial begin
    chk_en = 1;
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1;

    // 1: reset mid-stream with three busy entries
    iss(1); iss(2); iss(3);
    rst_n = 0; #1;
    chk("rst_tag",   64'(dec_tag),  64'd0);
    chk("rst_full",  64'(full),     64'd0);
    chk("rst_valid", 64'(rf_valid), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // 2: single issue, writeback, commit
    iss(5);
    cdb(0, 32'hDEADBEEF);
`ifdef ROB_COMMIT_BYPASS_EN
    chk("t2_valid", 64'(rf_valid), 64'd1);
    chk("t2_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    idle();
`else
    chk("t2_early", 64'(rf_valid), 64'd0);
    idle();
    chk("t2_valid", 64'(rf_valid), 64'd1);
    chk("t2_rd",    64'(rf_rd),    64'd5);
    chk("t2_wdata", 64'(rf_wdata), 64'hDEADBEEF);
`endif

    // freeze: ready entry must not retire and issue must not allocate while rdy is low
    iss(4); cdb(1, 32'h1111);
    rdy = 0; iss(9); idle();
    chk("frz_tag", 64'(dec_tag), 64'd2);
    rdy = 1; idle(); idle();

    // 3: out-of-order completion, in-order retirement
    fl();
    iss(6); iss(7); iss(8);
    cdb(2, 32'h22); cdb(1, 32'h11); cdb(0, 32'h00);
    idle(); idle(); idle(); idle();
    chk("t3_lasttag", 64'(rf_tag), 64'd2);
    chk("t3_lastrd",  64'(rf_rd),  64'd8);

    // 4: fill, reject ninth, wrap
    fl();
    for (int i = 0; i < 8; i++) iss(5'(10 + i));
    chk("t4_full", 64'(full),    64'd1);
    chk("t4_tag",  64'(dec_tag), 64'd0);
    iss(30);
    chk("t4_rej",  64'(full),    64'd1);
    cdb(0, 32'hA0); idle();
    chk("t4_free", 64'(full),    64'd0);
    chk("t4_wrap", 64'(dec_tag), 64'd0);
    iss(18);
    chk("t4_refull", 64'(full), 64'd1);
    cdb(1, 32'hA1);
    iss(19);  // full pre-edge: rejected even if head retires this edge
`ifndef ROB_COMMIT_BYPASS_EN
    chk("t4_fullrej", 64'(full),    64'd0);
    chk("t4_fulltag", 64'(dec_tag), 64'd1);
`endif
    for (int i = 2; i < 8; i++) cdb(3'(i), 32'hB0 + i);
    idle(); idle(); idle();

    // 5: silent retirement of x0 and no-rd entries
    fl();
    step(1, 0, 9, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    cdb(0, 32'h55); cdb(1, 32'h66); idle(); idle();
    chk("t5_valid", 64'(rf_valid), 64'd0);
    chk("t5_tag",   64'(rf_tag),   64'd1);

    // 6: flush dominates issue, writeback and a ready head
    fl();
    iss(3); iss(4); cdb(0, 32'h77);
    step(1, 1, 7, 1, 1, 32'h88, 1);
    chk("t6_valid", 64'(rf_valid), 64'd0);
    chk("t6_tag",   64'(dec_tag),  64'd0);
    chk("t6_full",  64'(full),     64'd0);
    iss(12);
    chk("t6_next",  64'(dec_tag),  64'd1);
    cdb(0, 32'h99); idle(); idle();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
